// File: rtl/spectrum_frame_collector.sv
// spectrum_frame_collector
//   Merges magnitude streams from NUM_FFT FFT engines into one tagged stream
//   {bin_index, magnitude}. Each engine has its own bin counter; engines are
//   arbitrated round-robin into a single output register with valid/ready.
//   A one-cycle frame_done pulse marks the terminal bin of a frame leaving the
//   output. With HALF_SPECTRUM=1 only bins 0..FFT_POINTS/2-1 are forwarded;
//   upper bins are accepted and discarded.
//
// Optional feature macro: COLLECTOR_PEAK_TRACK_EN
//   Adds peak_mag/peak_bin (valid with frame_done): per-channel running maximum
//   over forwarded bins of the completed frame, ties keep the lower bin.
//
// Ports
//   clk, reset_n             clock, synchronous active-low reset
//   mag_valid/mag_data/      per-engine input stream, channel c at
//   mag_ready                  mag_data[c*MAG_W +: MAG_W]
//   out_valid/out_ready/     tagged output stream
//   out_data/out_chan
//   frame_done/frame_chan    frame completion pulse and its source engine
//   frame_count              completed frames since reset (wraps)
//   peak_mag/peak_bin        frame maximum (COLLECTOR_PEAK_TRACK_EN only)

module spectrum_frame_collector #(
  parameter int unsigned NUM_FFT       = 3,
  parameter int unsigned FFT_POINTS    = 512,
  parameter int unsigned MAG_W         = 16,
  parameter bit          HALF_SPECTRUM = 1'b0,
  localparam int unsigned IDX_W        = $clog2(FFT_POINTS),
  localparam int unsigned CH_W         = (NUM_FFT > 1) ? $clog2(NUM_FFT) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_FFT-1:0]       mag_valid,
  input  logic [NUM_FFT*MAG_W-1:0] mag_data,
  output logic [NUM_FFT-1:0]       mag_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W+MAG_W-1:0]   out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic                     frame_done,
  output logic [CH_W-1:0]          frame_chan,
`ifdef COLLECTOR_PEAK_TRACK_EN
  output logic [MAG_W-1:0]         peak_mag,
  output logic [IDX_W-1:0]         peak_bin,
`endif
  output logic [15:0]              frame_count
);

  localparam logic [IDX_W-1:0] HalfIdx = IDX_W'(FFT_POINTS / 2);
  localparam logic [IDX_W-1:0] TermIdx = HALF_SPECTRUM ? IDX_W'(FFT_POINTS / 2 - 1)
                                                       : IDX_W'(FFT_POINTS - 1);

  logic [IDX_W-1:0]       bin_cnt_q [NUM_FFT];
  logic [IDX_W-1:0]       bin_cnt_d [NUM_FFT];
  logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [IDX_W+MAG_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]        out_chan_q, out_chan_d;
  logic                   frame_done_q, frame_done_d;
  logic [CH_W-1:0]        frame_chan_q, frame_chan_d;
  logic [15:0]            frame_count_q, frame_count_d;

  logic [MAG_W-1:0]       mag_ch [NUM_FFT];
  logic [NUM_FFT-1:0]     drop;
  logic [NUM_FFT-1:0]     eligible;
  logic                   slot_free;
  logic                   grant_vld;
  logic [CH_W-1:0]        grant_idx;
  logic [CH_W-1:0]        cand;
  logic [MAG_W-1:0]       grant_mag;
  logic [IDX_W-1:0]       grant_bin;
  logic                   grant_drop;
  logic                   load;
  logic                   out_fire;

  // Round-robin grant. A channel whose next bin is dropped never needs the
  // output slot, so it stays eligible while the slot is blocked.
  always_comb begin
    slot_free = !out_valid_q | out_ready;
    mag_ch    = '{default: '0};
    drop      = '0;
    eligible  = '0;
    for (int c = 0; c < NUM_FFT; c++) begin
      mag_ch[c]   = mag_data[c*MAG_W +: MAG_W];
      drop[c]     = HALF_SPECTRUM && (bin_cnt_q[c] >= HalfIdx);
      eligible[c] = mag_valid[c] & (slot_free | drop[c]);
    end
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_FFT; i++) begin
      cand = CH_W'((int'(rr_ptr_q) + i) % int'(NUM_FFT));
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (!reset_n) begin
      grant_vld = 1'b0;
    end
    mag_ready  = grant_vld ? (NUM_FFT'(1) << grant_idx) : '0;
    grant_mag  = mag_ch[grant_idx];
    grant_bin  = bin_cnt_q[grant_idx];
    grant_drop = drop[grant_idx];
    load       = grant_vld & ~grant_drop;
    out_fire   = out_valid_q & out_ready;
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_chan_d    = out_chan_q;
    bin_cnt_d     = bin_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    frame_done_d  = out_fire && (out_data_q[MAG_W +: IDX_W] == TermIdx);
    frame_chan_d  = frame_done_d ? out_chan_q : frame_chan_q;
    frame_count_d = frame_count_q + 16'(frame_done_d);

    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = {grant_bin, grant_mag};
      out_chan_d  = grant_idx;
    end
    if (grant_vld) begin
      // FFT_POINTS is a power of two, so the counter wraps naturally.
      bin_cnt_d[grant_idx] = grant_bin + 1'b1;
      rr_ptr_d = (grant_idx == CH_W'(NUM_FFT - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_cnt_q     <= '{default: '0};
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_chan_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_chan_q  <= '0;
      frame_count_q <= '0;
    end else begin
      bin_cnt_q     <= bin_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_chan_q    <= out_chan_d;
      frame_done_q  <= frame_done_d;
      frame_chan_q  <= frame_chan_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_chan    = out_chan_q;
  assign frame_done  = frame_done_q;
  assign frame_chan  = frame_chan_q;
  assign frame_count = frame_count_q;

`ifdef COLLECTOR_PEAK_TRACK_EN
  logic [MAG_W-1:0] pk_mag_q [NUM_FFT];
  logic [MAG_W-1:0] pk_mag_d [NUM_FFT];
  logic [IDX_W-1:0] pk_bin_q [NUM_FFT];
  logic [IDX_W-1:0] pk_bin_d [NUM_FFT];
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic [IDX_W-1:0] peak_bin_q, peak_bin_d;

  // Bin 0 starts a new frame and seeds the maximum; strict compare keeps the
  // lower bin on ties. The terminal beat was folded in when it was loaded,
  // so the channel maximum is complete by the time it leaves the output.
  always_comb begin
    pk_mag_d   = pk_mag_q;
    pk_bin_d   = pk_bin_q;
    peak_mag_d = peak_mag_q;
    peak_bin_d = peak_bin_q;
    if (load) begin
      if (grant_bin == '0) begin
        pk_mag_d[grant_idx] = grant_mag;
        pk_bin_d[grant_idx] = '0;
      end else if (grant_mag > pk_mag_q[grant_idx]) begin
        pk_mag_d[grant_idx] = grant_mag;
        pk_bin_d[grant_idx] = grant_bin;
      end
    end
    if (frame_done_d) begin
      peak_mag_d = pk_mag_q[out_chan_q];
      peak_bin_d = pk_bin_q[out_chan_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pk_mag_q   <= '{default: '0};
      pk_bin_q   <= '{default: '0};
      peak_mag_q <= '0;
      peak_bin_q <= '0;
    end else begin
      pk_mag_q   <= pk_mag_d;
      pk_bin_q   <= pk_bin_d;
      peak_mag_q <= peak_mag_d;
      peak_bin_q <= peak_bin_d;
    end
  end

  assign peak_mag = peak_mag_q;
  assign peak_bin = peak_bin_q;
`endif

endmodule

// File: doc/spectrum_frame_collector.md
Name: spectrum_frame_collector

Overview:
- Parametrised successor to the single-index, three-engine magnitude mux in shazam_core.
- Merges magnitude streams from NUM_FFT FFT engines into one tagged stream {bin_index, magnitude} for find_maximas.
- Keeps a private bin counter per engine and arbitrates round-robin with valid/ready backpressure.
- Emits a per-frame completion pulse, used to start peak search, and can forward only the lower half of the spectrum.

Parameters:
- NUM_FFT, 3, number of FFT engine input channels (1..8)
- FFT_POINTS, 512, bins per frame; power of two, >= 4
- MAG_W, 16, magnitude width
- HALF_SPECTRUM, 0, 1 = forward only bins 0..FFT_POINTS/2-1; upper bins accepted and dropped
- IDX_W, $clog2(FFT_POINTS), bin index width (derived, not overridden)
- CH_W, max(1,$clog2(NUM_FFT)), channel id width (derived)

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- mag_valid  in  NUM_FFT  per-engine magnitude valid
- mag_data  in  NUM_FFT*MAG_W  flattened magnitudes; channel c at [c*MAG_W +: MAG_W]
- mag_ready  out  NUM_FFT  per-engine accept
- out_valid  out  1  tagged magnitude valid
- out_ready  in  1  downstream accept
- out_data  out  IDX_W+MAG_W  {bin_index, magnitude}
- out_chan  out  CH_W  source engine of out_data
- frame_done  out  1  one-cycle pulse: last bin of a frame left the output
- frame_chan  out  CH_W  engine whose frame completed; valid with frame_done
- frame_count  out  16  completed frames since reset; wraps 0xFFFF->0

Behaviour:
- Reset (reset_n=0 at posedge): out_valid=0, out_data=0, out_chan=0, frame_done=0, frame_chan=0, frame_count=0, mag_ready=0, all bin counters=0, RR pointer=0. Reset mid-frame discards partial frames; no frame_done.
- Handshakes: an input beat transfers when mag_valid[c] & mag_ready[c]; an output beat when out_valid & out_ready. out_valid/out_data are held stable until accepted.
- Output slot: one register. slot_free = !out_valid | out_ready.
- Arbitration (combinational grant): at most one mag_ready bit high per cycle, and only when slot_free. Round-robin starts from the RR pointer. After a grant to channel g, the pointer becomes g+1 mod NUM_FFT.
- Drop path: a channel holding a dropped bin (HALF_SPECTRUM=1, bin>=FFT_POINTS/2) competes in the same arbitration. On grant it is consumed without loading the slot.
- Latency: an accepted input appears on out_data the next cycle (1 cycle). Full throughput is 1 beat/cycle with out_ready=1.
- Bin counter: channel c's counter increments on each transfer of channel c, wrapping FFT_POINTS-1 -> 0. out_data index = counter value before increment.
- Frame end (terminal bin): FFT_POINTS-1, or FFT_POINTS/2-1 when HALF_SPECTRUM=1.
  - When the terminal beat is accepted on the output: frame_done=1 for exactly the next cycle, frame_chan=its channel, frame_count+1.
  - Bins past the half-point of a HALF_SPECTRUM frame are dropped silently.
- Simultaneous events:
  - Two channels ending frames on consecutive cycles give two separate frame_done pulses.
  - frame_done never merges pulses, since only one output beat is accepted per cycle.
- Backpressure: with out_ready=0 and out_valid=1, every mag_ready=0 except channels that can be granted on the drop path.
- Width rules:
  - out_data = {idx[IDX_W-1:0], mag[MAG_W-1:0]}; no arithmetic on the magnitude.
  - For the defaults (FFT_POINTS=512, MAG_W=16) this gives 25 bits, matching the find_maximas data_in format.

Optional Feature:
- Macro: COLLECTOR_PEAK_TRACK_EN.
- Defined: adds outputs peak_mag [MAG_W] and peak_bin [IDX_W], valid with frame_done.
  - Per-channel running maximum over forwarded bins; ties keep the lower bin.
  - Per-channel maxima are cleared at frame start and on reset (peak_mag=0, peak_bin=0).
  - Adds NUM_FFT*(MAG_W+IDX_W) flops.
- Undefined: ports are absent and no tracking logic is built. All other behaviour is identical.

Test Plan:
- Single engine: NUM_FFT=3, ch0 streams 512 beats (mag=bin*3), out_ready=1.
  - out_data indexes 0..511 in order, each 1 cycle after input.
  - One frame_done, frame_chan=0, frame_count=1.
- Contention: ch0, ch1 and ch2 all valid continuously for 6 cycles, pointer=0.
  - Grants ch0,ch1,ch2,ch0,ch1,ch2.
  - Each channel's out_data indexes are 0,1; out_chan follows the grant order.
- Backpressure: out_ready low for 4 cycles during streaming.
  - out_data is held and mag_ready=0.
  - No beat is lost or duplicated; indexes stay contiguous per channel.
- HALF_SPECTRUM=1, ch1 streams 512 beats.
  - Only 256 out beats (idx 0..255); frame_done after idx 255; beats 256..511 are consumed with out_valid unaffected.
- Reset mid-frame: reset_n=0 for 1 cycle after ch0 bin 100.
  - All outputs return to reset values.
  - The next ch0 beat is tagged idx 0 and no frame_done occurs for the aborted frame.
- COLLECTOR_PEAK_TRACK_EN: frame with mag 50 at bins 37 and 90, all other mags < 50.
  - At frame_done: peak_mag=50, peak_bin=37.
